// File: rtl/alu_sweeper.sv
// Self-test sequencer that sweeps all 256 {sel,a,b} vectors through an external 4-bit ALU.
// It compares each result against a built-in reference and reports the mismatch count and the first failure.
module alu_sweeper #(
    parameter int unsigned LATENCY = 1
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] alu_out,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [3:0] alu_sel,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] first_fail,
    output logic [3:0] first_got
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Last value of the wait counter before CHECK; only used when LATENCY > 1.
    localparam logic [1:0] WAIT_LAST = (LATENCY > 32'd1) ? 2'(LATENCY - 32'd2) : 2'd0;

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [1:0] wcnt_q, wcnt_d;
    logic [7:0] err_q, err_d;
    logic [7:0] ffail_q, ffail_d;
    logic [3:0] fgot_q, fgot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] expect_s;

    function automatic logic [3:0] alu_expect(input logic [3:0] sel, input logic [1:0] a,
                                              input logic [1:0] b);
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] r;
        ea = {2'b00, a};
        eb = {2'b00, b};
        case (sel)
            4'd0, 4'd1: r = ea + eb;
            4'd2:       r = ea - eb;
            4'd3:       r = eb - ea;
            4'd4:       r = ea * eb;
            4'd5:       r = ea & eb;
            4'd6:       r = ea | eb;
            4'd7:       r = ea ^ eb;
            4'd8:       r = {3'b000, a[1]};
            4'd9:       r = {1'b0, a, 1'b0};
            4'd10:      r = {3'b000, b[1]};
            4'd11:      r = {1'b0, b, 1'b0};
            4'd12:      r = {3'b000, a[1]};
            4'd13:      r = {3'b000, b[1]};
            4'd14:      r = {3'b000, (a == b)};
            4'd15:      r = {3'b000, (a > b)};
            default:    r = 4'd0;
        endcase
        return r;
    endfunction

    assign expect_s = alu_expect(idx_q[7:4], idx_q[3:2], idx_q[1:0]);

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        ffail_d = ffail_q;
        fgot_d  = fgot_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = 8'd0;
                    err_d   = 8'd0;
                    ffail_d = 8'd0;
                    fgot_d  = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (LATENCY == 32'd1) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = 2'd0;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (alu_out != expect_s) begin
                        // A zero count means no mismatch yet in this sweep, since the count saturates.
                        if (err_q == 8'd0) begin
                            ffail_d = idx_q;
                            fgot_d  = alu_out;
                        end else begin
                            ffail_d = ffail_q;
                        end
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (idx_q == 8'hFF) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRIVE;
                        idx_d   = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_comb begin
        busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == 8'd0);
    end

    // State and result registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            idx_q   <= 8'd0;
            wcnt_q  <= 2'd0;
            err_q   <= 8'd0;
            ffail_q <= 8'd0;
            fgot_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            ffail_q <= ffail_d;
            fgot_q  <= fgot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign alu_sel    = idx_q[7:4];
    assign alu_a      = idx_q[3:2];
    assign alu_b      = idx_q[1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ffail_q;
    assign first_got  = fgot_q;

endmodule

// File: tb/tb_alu_sweeper.sv
// Directed bench for alu_sweeper: reference ALU models with 1- and 3-cycle latency, fault modes,
// abort and mid-sweep reset scenarios.
module tb_alu_sweeper;

    logic       clk;
    logic       res;
    logic       start1, abort1, start3, abort3;
    logic [3:0] out1, out3;
    logic [1:0] a1, b1, a3, b3;
    logic [3:0] sel1, sel3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [7:0] err1, ff1, err3, ff3;
    logic [3:0] fg1, fg3;
    logic [3:0] p3_0, p3_1;
    int         fault_mode;
    int         n_checks;
    int         n_fail;

    alu_sweeper #(.LATENCY(1)) u_dut1 (
        .clk(clk), .res(res), .start(start1), .abort(abort1), .alu_out(out1),
        .alu_a(a1), .alu_b(b1), .alu_sel(sel1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail(ff1), .first_got(fg1)
    );

    alu_sweeper #(.LATENCY(3)) u_dut3 (
        .clk(clk), .res(res), .start(start3), .abort(abort3), .alu_out(out3),
        .alu_a(a3), .alu_b(b3), .alu_sel(sel3), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .first_fail(ff3), .first_got(fg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU in plain integer arithmetic; mode 1 corrupts sel=4,a=3,b=3, mode 2 is stuck at F.
    function automatic logic [3:0] ref_alu(input logic [3:0] s, input logic [1:0] a,
                                           input logic [1:0] b, input int mode);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        if (mode == 2) return 4'hF;
        if (mode == 1 && s == 4'd4 && a == 2'd3 && b == 2'd3) return 4'h0;
        case (int'(s))
            0, 1:    r = ia + ib;
            2:       r = ia - ib + 16;
            3:       r = ib - ia + 16;
            4:       r = ia * ib;
            5:       r = ia & ib;
            6:       r = ia | ib;
            7:       r = ia ^ ib;
            8:       r = ia / 2;
            9:       r = ia * 2;
            10:      r = ib / 2;
            11:      r = ib * 2;
            12:      r = (ia >= 2) ? 1 : 0;
            13:      r = (ib >= 2) ? 1 : 0;
            14:      r = (ia == ib) ? 1 : 0;
            15:      r = (ia > ib) ? 1 : 0;
            default: r = 0;
        endcase
        r = r % 16;
        return r[3:0];
    endfunction

    always @(posedge clk) begin
        out1 <= ref_alu(sel1, a1, b1, fault_mode);
        p3_0 <= ref_alu(sel3, a3, b3, fault_mode);
        p3_1 <= p3_0;
        out3 <= p3_1;
    end

    function automatic logic [7:0] get_idx(input int inst);
        return (inst == 3) ? {sel3, a3, b3} : {sel1, a1, b1};
    endfunction

    function automatic logic get_done(input int inst);
        return (inst == 3) ? done3 : done1;
    endfunction

    task automatic set_start(input int inst, input logic v);
        if (inst == 3) start3 = v;
        else start1 = v;
    endtask

    // Starts a sweep and waits for done; reports edges from the start edge and vector-order integrity.
    task automatic run_sweep(input int inst, input int budget, input int pulse_at,
                             output int cycles, output bit seq_ok, output logic busy_e0);
        int         lat;
        int         run;
        logic [7:0] prev;
        logic [7:0] cur;
        bit         fin;
        lat = (inst == 3) ? 3 : 1;
        @(negedge clk);
        set_start(inst, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(inst, 1'b0);
        busy_e0 = (inst == 3) ? busy3 : busy1;
        cycles = 0;
        seq_ok = (get_idx(inst) == 8'd0);
        prev = 8'd0;
        run = 1;
        fin = 1'b0;
        while (!fin && cycles < budget) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            set_start(inst, (cycles == pulse_at) ? 1'b1 : 1'b0);
            if (get_done(inst)) begin
                fin = 1'b1;
            end else begin
                cur = get_idx(inst);
                if (cur == prev) begin
                    run++;
                end else begin
                    if (run != lat + 1 || cur != prev + 8'd1) seq_ok = 1'b0;
                    prev = cur;
                    run = 1;
                end
            end
        end
        set_start(inst, 1'b0);
    endtask

    task automatic test_reset();
        res = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        fault_mode = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a1, b1, sel1, busy1, done1, pass1, err1, ff1, fg1} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1: got %h expected 0", {a1, b1, sel1, busy1, done1, pass1, err1, ff1, fg1});
        end
        n_checks++;
        if ({a3, b3, sel3, busy3, done3, pass3, err3, ff3, fg3} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat3: got %h expected 0", {a3, b3, sel3, busy3, done3, pass3, err3, ff3, fg3});
        end
        res = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy1, done1);
        end
    endtask

    task automatic test_golden();
        int cyc; bit ok; logic b0;
        fault_mode = 0;
        run_sweep(1, 2000, 100, cyc, ok, b0);
        n_checks++;
        if (b0 !== 1'b1) begin n_fail++; $display("FAIL golden_busy_e0: got %b expected 1", b0); end
        n_checks++;
        if (cyc != 512) begin n_fail++; $display("FAIL golden_cycles: got %0d expected 512", cyc); end
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL golden_vector_order: got %b expected 1", ok); end
        n_checks++;
        if ({done1, busy1, pass1} !== 3'b101) begin
            n_fail++; $display("FAIL golden_flags: got done,busy,pass=%b expected 101", {done1, busy1, pass1});
        end
        n_checks++;
        if (err1 !== 8'd0) begin n_fail++; $display("FAIL golden_err_cnt: got %0d expected 0", err1); end
        n_checks++;
        if ({sel1, a1, b1} !== 8'hFF) begin n_fail++; $display("FAIL golden_hold_last: got %h expected ff", {sel1, a1, b1}); end
    endtask

    task automatic test_single_fault();
        int cyc; bit ok; logic b0;
        fault_mode = 1;
        run_sweep(1, 2000, -1, cyc, ok, b0);
        n_checks++;
        if (err1 !== 8'd1) begin n_fail++; $display("FAIL fault_err_cnt: got %0d expected 1", err1); end
        n_checks++;
        if (ff1 !== 8'h4F) begin n_fail++; $display("FAIL fault_first_fail: got %h expected 4f", ff1); end
        n_checks++;
        if (fg1 !== 4'h0) begin n_fail++; $display("FAIL fault_first_got: got %h expected 0", fg1); end
        n_checks++;
        if ({done1, pass1} !== 2'b10) begin n_fail++; $display("FAIL fault_done_pass: got %b expected 10", {done1, pass1}); end
    endtask

    task automatic test_stuck();
        int cyc; bit ok; logic b0;
        fault_mode = 2;
        run_sweep(1, 2000, -1, cyc, ok, b0);
        // Only sel 2 and sel 3 produce F (three vectors each), so 250 mismatches.
        n_checks++;
        if (err1 !== 8'd250) begin n_fail++; $display("FAIL stuck_err_cnt: got %0d expected 250", err1); end
        n_checks++;
        if (ff1 !== 8'h00) begin n_fail++; $display("FAIL stuck_first_fail: got %h expected 00", ff1); end
        n_checks++;
        if (fg1 !== 4'hF) begin n_fail++; $display("FAIL stuck_first_got: got %h expected f", fg1); end
        n_checks++;
        if (pass1 !== 1'b0) begin n_fail++; $display("FAIL stuck_pass: got %b expected 0", pass1); end
    endtask

    task automatic test_abort();
        int  n;
        bit  fin;
        fault_mode = 2;
        @(negedge clk);
        start1 = 1'b1;
        n = 0;
        fin = 1'b0;
        while (!fin && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ({sel1, a1, b1} == 8'd10) fin = 1'b1;
        end
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL abort_reach_idx10: got timeout expected index 10"); end
        abort1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy1, done1} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got busy,done=%b expected 00", {busy1, done1}); end
        n_checks++;
        if (err1 !== 8'd10 || ff1 !== 8'h00) begin
            n_fail++; $display("FAIL abort_retain: got err=%0d ff=%h expected 10 00", err1, ff1);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_wins_over_start: got busy=%b expected 0", busy1); end
        abort1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        n_checks++;
        if ({busy1, err1, sel1, a1, b1} !== 17'h10000) begin
            n_fail++; $display("FAIL abort_restart: got busy=%b err=%0d idx=%h expected 1 0 00", busy1, err1, {sel1, a1, b1});
        end
        n = 0;
        while (done1 !== 1'b1 && n < 1200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (done1 !== 1'b1 || err1 !== 8'd250) begin
            n_fail++; $display("FAIL abort_full_rerun: got done=%b err=%0d expected 1 250", done1, err1);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok; logic b0;
        fault_mode = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        res = 1'b1;
        #1;
        n_checks++;
        if ({a1, b1, sel1, busy1, done1, pass1, err1, ff1, fg1} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h expected 0", {a1, b1, sel1, busy1, done1, pass1, err1, ff1, fg1});
        end
        @(negedge clk);
        res = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy1, done1, sel1, a1, b1} !== 10'd0) begin
            n_fail++; $display("FAIL reset_mid_idle: got busy,done,idx=%h expected 0", {busy1, done1, sel1, a1, b1});
        end
        run_sweep(1, 2000, -1, cyc, ok, b0);
        n_checks++;
        if (cyc != 512 || pass1 !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_resweep: got cycles=%0d pass=%b expected 512 1", cyc, pass1);
        end
    endtask

    task automatic test_latency3();
        int cyc; bit ok; logic b0;
        fault_mode = 0;
        run_sweep(3, 3000, -1, cyc, ok, b0);
        n_checks++;
        if (cyc != 1024) begin n_fail++; $display("FAIL lat3_cycles: got %0d expected 1024", cyc); end
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL lat3_operand_stability: got %b expected 1", ok); end
        n_checks++;
        if ({pass3, err3} !== 9'h100) begin n_fail++; $display("FAIL lat3_pass: got pass=%b err=%0d expected 1 0", pass3, err3); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_golden();
        test_single_fault();
        test_stuck();
        test_abort();
        test_reset_mid();
        test_latency3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
